t09_head_stepper: RTL and testbench

T09_HEAD_STEPPER -- requirements
Module: t09_head_stepper

---
 rtl/t09_head_stepper.sv | 102 ++++++++++
 tb/tb_t09_head_stepper.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/t09_head_stepper.sv
// Grid head stepper: moves a head one cell per game tick, with wall death or
// wrap-around, a saturating move counter and a restart request.
module t09_head_stepper #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 12,
    parameter int START_X = 7,
    parameter int START_Y = 5,
    parameter int WRAP    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] direction,
    input  logic       pulse,
    input  logic       sync,
    output logic [3:0] head_x,
    output logic [3:0] head_y,
    output logic       moved,
    output logic       game_over,
    output logic [7:0] move_count
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic signed [5:0] X_MAX   = 6'(GRID_W - 1);
    localparam logic signed [5:0] Y_MAX   = 6'(GRID_H - 1);
    localparam logic [3:0]        X_START = 4'(START_X);
    localparam logic [3:0]        Y_START = 4'(START_Y);
    localparam bit                WRAP_EN = (WRAP != 0);

    state_t            state, state_nxt;
    logic [3:0]        x_nxt, y_nxt;
    logic              moved_nxt, over_nxt;
    logic [7:0]        cnt_nxt;
    logic signed [5:0] cx, cy;
    logic              step, off_grid;

    always_comb begin
        state_nxt = state;
        x_nxt     = head_x;
        y_nxt     = head_y;
        moved_nxt = 1'b0;
        over_nxt  = game_over;
        cnt_nxt   = move_count;

        // Widened signed candidate so stepping below 0 shows up as negative.
        cx = $signed({2'b00, head_x});
        cy = $signed({2'b00, head_y});
        case (direction)
            3'd0:    cy = cy - 6'sd1;
            3'd1:    cy = cy + 6'sd1;
            3'd2:    cx = cx - 6'sd1;
            3'd3:    cx = cx + 6'sd1;
            default: ;
        endcase

        step     = pulse && (direction <= 3'd3) && (state != DEAD);
        off_grid = (cx < 6'sd0) || (cx > X_MAX) || (cy < 6'sd0) || (cy > Y_MAX);

        if (cx < 6'sd0)      cx = X_MAX;
        else if (cx > X_MAX) cx = 6'sd0;
        if (cy < 6'sd0)      cy = Y_MAX;
        else if (cy > Y_MAX) cy = 6'sd0;

        if (sync) begin
            state_nxt = IDLE;
            x_nxt     = X_START;
            y_nxt     = Y_START;
            over_nxt  = 1'b0;
            cnt_nxt   = 8'd0;
        end else if (step) begin
            if (off_grid && !WRAP_EN) begin
                state_nxt = DEAD;
                over_nxt  = 1'b1;
            end else begin
                state_nxt = RUN;
                x_nxt     = cx[3:0];
                y_nxt     = cy[3:0];
                moved_nxt = 1'b1;
                cnt_nxt   = (move_count == 8'hFF) ? move_count : move_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            head_x     <= X_START;
            head_y     <= Y_START;
            moved      <= 1'b0;
            game_over  <= 1'b0;
            move_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            head_x     <= x_nxt;
            head_y     <= y_nxt;
            moved      <= moved_nxt;
            game_over  <= over_nxt;
            move_count <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_t09_head_stepper.sv
// Directed bench for t09_head_stepper: a wall-death and a wrapping instance
// share one stimulus stream, checked against a queued reference model.
module tb_t09_head_stepper;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       moved;
        logic       go;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        int x, y, cnt, st;   // st: 0 idle, 1 run, 2 dead
        bit go, moved;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] direction = 3'd0;
    logic       pulse = 1'b0;
    logic       sync = 1'b0;

    logic [3:0] x0, y0, x1, y1;
    logic       mv0, go0, mv1, go1;
    logic [7:0] cnt0, cnt1;

    int   vectors = 0;
    int   miscompares = 0;
    mdl_t m0, m1;
    obs_t q0[$], q1[$];

    always #5 clk = ~clk;

    t09_head_stepper #(.WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .direction(direction), .pulse(pulse), .sync(sync),
        .head_x(x0), .head_y(y0), .moved(mv0), .game_over(go0), .move_count(cnt0)
    );

    t09_head_stepper #(.WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .direction(direction), .pulse(pulse), .sync(sync),
        .head_x(x1), .head_y(y1), .moved(mv1), .game_over(go1), .move_count(cnt1)
    );

    function automatic mdl_t mstep(mdl_t s, bit wrap, bit r, bit sy, bit p, int d);
        mdl_t n;
        int nx, ny;
        bit out;
        n = s;
        n.moved = 0;
        if (r || sy) begin
            n.x = 7; n.y = 5; n.cnt = 0; n.go = 0; n.st = 0;
        end else if (p && d < 4 && s.st != 2) begin
            nx = s.x + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0);
            ny = s.y + (d == 1 ? 1 : 0) - (d == 0 ? 1 : 0);
            out = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 11);
            if (out && !wrap) begin
                n.st = 2; n.go = 1;
            end else begin
                n.x = (nx + 16) % 16;
                n.y = (ny + 12) % 12;
                n.moved = 1;
                n.cnt = (s.cnt >= 255) ? 255 : s.cnt + 1;
                n.st = 1;
            end
        end
        return n;
    endfunction

    function automatic obs_t to_obs(mdl_t m);
        obs_t o;
        o.x = 4'(m.x); o.y = 4'(m.y); o.moved = m.moved; o.go = m.go; o.cnt = 8'(m.cnt);
        return o;
    endfunction

    task automatic tick(input bit r, input bit sy, input bit p, input int d);
        obs_t e0, e1, a0, a1;
        @(negedge clk);
        rst = r; sync = sy; pulse = p; direction = 3'(d);
        m0 = mstep(m0, 1'b0, r, sy, p, d);
        m1 = mstep(m1, 1'b1, r, sy, p, d);
        q0.push_back(to_obs(m0));
        q1.push_back(to_obs(m1));
        @(posedge clk);
        #1;
        a0 = {x0, y0, mv0, go0, cnt0};
        a1 = {x1, y1, mv1, go1, cnt1};
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        vectors += 2;
        assert (a0 === e0) else begin
            miscompares++;
            $error("FAIL nowrap obs=%h exp=%h", a0, e0);
        end
        assert (a1 === e1) else begin
            miscompares++;
            $error("FAIL wrap obs=%h exp=%h", a1, e1);
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        m0 = '{x:7, y:5, cnt:0, st:0, go:0, moved:0};
        m1 = m0;

        // reset state
        tick(1, 0, 0, 0);
        check("rst_xy", {x0, y0}, 8'h75);
        check("rst_flags", {mv0, go0, cnt0}, 0);

        // first move right from IDLE
        tick(0, 0, 1, 3);
        check("first_xy", {x0, y0}, 8'h85);
        check("first_mv_cnt", {mv0, cnt0}, {1'b1, 8'd1});
        tick(0, 0, 0, 3);
        check("nopulse_mv", mv0, 0);

        // STOP and codes 5..7 hold position
        tick(0, 1, 0, 0);
        tick(0, 0, 1, 4);
        tick(0, 0, 1, 6);
        check("stop_xy", {x0, y0, mv0, cnt0}, {8'h75, 1'b0, 8'd0});
        tick(0, 0, 1, 7);

        // six UPs: no-wrap dies at the top wall, wrap goes to row 11
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 0);
        check("up_die_xy", {x0, y0}, 8'h70);
        check("up_die_go_cnt", {go0, cnt0}, {1'b1, 8'd5});
        check("up_wrap_y", y1, 11);
        tick(0, 0, 1, 1);
        check("dead_hold", {x0, y0, mv0, cnt0}, {8'h70, 1'b0, 8'd5});
        tick(0, 0, 0, 1);

        // nine RIGHTs: wrap passes (15,5) into (0,5)
        tick(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 3);
        check("right_15", {x1, y1}, 8'hF5);
        tick(0, 0, 1, 3);
        check("right_wrap", {x1, y1, go1, cnt1}, {8'h05, 1'b0, 8'd9});
        check("right_die", {x0, go0}, {4'hF, 1'b1});

        // sync beats pulse while running at (3,3)
        tick(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 2);
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        check("at_33", {x0, y0}, 8'h33);
        tick(0, 1, 1, 0);
        check("sync_win", {x0, y0, mv0, cnt0}, {8'h75, 1'b0, 8'd0});

        // rst beats sync and pulse mid-game
        tick(0, 0, 1, 1);
        tick(0, 0, 1, 1);
        tick(1, 1, 1, 1);
        check("rst_mid", {x0, y0, cnt0}, {8'h75, 8'd0});

        // left wall: no-wrap dies at x=0, wrap goes to 15
        for (int i = 0; i < 8; i++) tick(0, 0, 1, 2);
        check("left_wall", {x0, go0, x1, go1}, {4'h0, 1'b1, 4'hF, 1'b0});
        tick(0, 0, 1, 3);

        // 260 alternating moves saturate the counter
        tick(0, 1, 0, 0);
        for (int i = 0; i < 260; i++) tick(0, 0, 1, (i % 2 == 0) ? 2 : 3);
        check("sat_cnt", cnt0, 255);
        check("sat_mv", mv0, 1);
        tick(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
